// File: rtl/design_out_signature_checker.sv
// Output-signature checker: after a start, waits CHANNEL settle cycles, compacts
// WINDOW samples of out_data into a MISR signature, then compares it with golden.
module design_out_signature_checker #(
  parameter int unsigned       WIDTH   = 32,
  parameter int unsigned       CHANNEL = 15,
  parameter int unsigned       WINDOW  = 64,
  parameter logic [WIDTH-1:0]  POLY    = WIDTH'(32'h04C11DB7)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] out_data,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      sample_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COLLECT, S_DONE} state_t;

  localparam int unsigned     CW          = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'((CHANNEL > 0) ? CHANNEL - 1 : 0);
  localparam logic [15:0]     WINDOW_LAST = 16'(WINDOW - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    settle_cnt_q, settle_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] signature_q, signature_d;
  logic [15:0]      sample_cnt_q, sample_cnt_d;
  logic [WIDTH-1:0] misr_next;
  logic             launch;
  logic             last_sample;

  assign misr_next   = (signature_q << 1) ^ (signature_q[WIDTH-1] ? POLY : '0) ^ out_data;
  assign launch      = (state_q == S_IDLE || state_q == S_DONE) && start;
  assign last_sample = (state_q == S_COLLECT) && (sample_cnt_q == WINDOW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      signature_q  <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      signature_q  <= signature_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (CHANNEL > 0) ? S_SETTLE : S_COLLECT;
      S_SETTLE:       if (settle_cnt_q == SETTLE_LAST) state_d = S_COLLECT;
      S_COLLECT:      if (last_sample) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered
  // alongside it and still line up with the state they describe.
  always_comb begin
    settle_cnt_d = '0;
    signature_d  = signature_q;
    sample_cnt_d = sample_cnt_q;
    pass_d       = pass_q;
    busy_d       = (state_d == S_SETTLE) || (state_d == S_COLLECT);
    done_d       = (state_d == S_DONE);
    if (state_q == S_SETTLE) settle_cnt_d = settle_cnt_q + CW'(1);
    if (launch) begin
      signature_d  = '0;
      sample_cnt_d = '0;
      pass_d       = 1'b0;
    end else if (state_q == S_COLLECT) begin
      signature_d  = misr_next;
      sample_cnt_d = sample_cnt_q + 16'd1;
      pass_d       = last_sample && (misr_next == golden);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = signature_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_design_out_signature_checker.sv
// Directed bench for design_out_signature_checker using three parameterisations:
// A (CHANNEL=15, WINDOW=4), B (CHANNEL=0, WINDOW=1), C (CHANNEL=0, WINDOW=2).
module tb_design_out_signature_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start_a, start_b, start_c;
  logic [31:0] data_a, data_b, data_c;
  logic [31:0] golden_a, golden_b, golden_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [31:0] sig_a, sig_b, sig_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  design_out_signature_checker #(.WIDTH(32), .CHANNEL(15), .WINDOW(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .out_data(data_a), .golden(golden_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .sample_cnt(cnt_a));

  design_out_signature_checker #(.WIDTH(32), .CHANNEL(0), .WINDOW(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .out_data(data_b), .golden(golden_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .sample_cnt(cnt_b));

  design_out_signature_checker #(.WIDTH(32), .CHANNEL(0), .WINDOW(2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .out_data(data_c), .golden(golden_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .sample_cnt(cnt_c));

  // MISR of constant 32'h80000001 over 4 samples with POLY 04C11DB7:
  // 80000001 -> 84C11DB4 -> 8D4326DE -> 9E47500A
  localparam logic [31:0] SIG_A = 32'h9E47500A;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (done_a) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    data_a = '0; data_b = '0; data_c = '0;
    golden_a = '0; golden_b = '0; golden_c = '0;
    #2;
    checks++;
    if ({busy_a, done_a, pass_a, sig_a, cnt_a} !== '0) begin
      errors++;
      $display("FAIL reset_a got busy=%b done=%b pass=%b sig=%h cnt=%0d exp all 0", busy_a, done_a, pass_a, sig_a, cnt_a);
    end
    checks++;
    if ({busy_b, done_b, pass_b, sig_b, cnt_b, busy_c, done_c, pass_c, sig_c, cnt_c} !== '0) begin
      errors++;
      $display("FAIL reset_bc got busy_b=%b done_b=%b sig_b=%h busy_c=%b sig_c=%h exp all 0", busy_b, done_b, sig_b, busy_c, sig_c);
    end
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy_a, done_a);
    end
  endtask

  task automatic test_zero_run();
    int lat;
    data_a = '0; golden_a = '0;
    start_a = 1; tick(); start_a = 0;
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy got busy=%b done=%b exp 1 0", busy_a, done_a);
    end
    wait_done_a(lat);
    checks++;
    if (lat !== 19) begin errors++; $display("FAIL zero_latency got %0d exp 19", lat); end
    checks++;
    if (sig_a !== 32'h0 || pass_a !== 1'b1 || cnt_a !== 16'd4) begin
      errors++;
      $display("FAIL zero_result got sig=%h pass=%b cnt=%0d exp 00000000 1 4", sig_a, pass_a, cnt_a);
    end
    repeat (3) tick();
    checks++;
    if (done_a !== 1'b1 || cnt_a !== 16'd4 || sig_a !== 32'h0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL zero_hold got done=%b cnt=%0d sig=%h busy=%b exp 1 4 00000000 0", done_a, cnt_a, sig_a, busy_a);
    end
  endtask

  task automatic test_single_window();
    data_b = 32'hABCDEFAB; golden_b = 32'hABCDEFAB;
    start_b = 1; tick(); start_b = 0;
    checks++;
    if (busy_b !== 1'b1 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL w1_busy got busy=%b done=%b exp 1 0", busy_b, done_b);
    end
    tick();
    checks++;
    if (done_b !== 1'b1 || sig_b !== 32'hABCDEFAB || pass_b !== 1'b1 || cnt_b !== 16'd1) begin
      errors++;
      $display("FAIL w1_result got done=%b sig=%h pass=%b cnt=%0d exp 1 abcdefab 1 1", done_b, sig_b, pass_b, cnt_b);
    end
  endtask

  task automatic test_mismatch();
    data_c = 32'h1; golden_c = 32'h2;
    start_c = 1; tick(); start_c = 0;
    tick();
    checks++;
    if (done_c !== 1'b0 || sig_c !== 32'h1 || cnt_c !== 16'd1) begin
      errors++;
      $display("FAIL w2_mid got done=%b sig=%h cnt=%0d exp 0 00000001 1", done_c, sig_c, cnt_c);
    end
    tick();
    checks++;
    if (done_c !== 1'b1 || sig_c !== 32'h3 || pass_c !== 1'b0 || cnt_c !== 16'd2) begin
      errors++;
      $display("FAIL w2_result got done=%b sig=%h pass=%b cnt=%0d exp 1 00000003 0 2", done_c, sig_c, pass_c, cnt_c);
    end
  endtask

  task automatic test_settle_ignore();
    golden_a = SIG_A;
    start_a = 1; tick(); start_a = 0;
    data_a = 32'hFFFFFFFF;
    repeat (15) tick();
    checks++;
    if (busy_a !== 1'b1 || sig_a !== 32'h0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL settle_ignore got busy=%b sig=%h cnt=%0d exp 1 00000000 0", busy_a, sig_a, cnt_a);
    end
    data_a = 32'h80000001;
    repeat (3) tick();
    checks++;
    if (done_a !== 1'b0 || sig_a !== 32'h8D4326DE || cnt_a !== 16'd3) begin
      errors++;
      $display("FAIL misr_step3 got done=%b sig=%h cnt=%0d exp 0 8d4326de 3", done_a, sig_a, cnt_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || sig_a !== SIG_A || pass_a !== 1'b1 || cnt_a !== 16'd4) begin
      errors++;
      $display("FAIL misr_result got done=%b sig=%h pass=%b cnt=%0d exp 1 %h 1 4", done_a, sig_a, pass_a, cnt_a, SIG_A);
    end
  endtask

  task automatic test_golden_mismatch();
    int lat;
    golden_a = SIG_A ^ 32'h1;
    start_a = 1; tick(); start_a = 0;
    checks++;
    if (sig_a !== 32'h0 || cnt_a !== 16'd0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear got sig=%h cnt=%0d done=%b pass=%b exp 00000000 0 0 0", sig_a, cnt_a, done_a, pass_a);
    end
    wait_done_a(lat);
    checks++;
    if (lat !== 19 || sig_a !== SIG_A || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL golden_miss got lat=%0d sig=%h pass=%b exp 19 %h 0", lat, sig_a, pass_a, SIG_A);
    end
    golden_a = SIG_A;
  endtask

  task automatic test_reset_mid_collect();
    int lat;
    start_a = 1; tick(); start_a = 0;
    repeat (17) tick();
    checks++;
    if (cnt_a !== 16'd2 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d busy=%b exp 2 1", cnt_a, busy_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_a, done_a, pass_a, sig_a, cnt_a} !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b pass=%b sig=%h cnt=%0d exp all 0", busy_a, done_a, pass_a, sig_a, cnt_a);
    end
    start_a = 1;
    #9;
    rst = 1'b0; start_a = 0;
    tick();
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL start_in_reset got busy=%b done=%b exp 0 0", busy_a, done_a);
    end
    start_a = 1; tick(); start_a = 0;
    wait_done_a(lat);
    checks++;
    if (lat !== 19 || sig_a !== SIG_A || pass_a !== 1'b1 || cnt_a !== 16'd4) begin
      errors++;
      $display("FAIL post_reset_run got lat=%0d sig=%h pass=%b cnt=%0d exp 19 %h 1 4", lat, sig_a, pass_a, cnt_a, SIG_A);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_a = 1;
    tick();
    wait_done_a(lat);
    checks++;
    if (lat !== 19 || sig_a !== SIG_A || pass_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d sig=%h pass=%b exp 19 %h 1", lat, sig_a, pass_a, SIG_A);
    end
    tick();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1 || sig_a !== 32'h0) begin
      errors++;
      $display("FAIL b2b_pulse got done=%b busy=%b sig=%h exp 0 1 00000000", done_a, busy_a, sig_a);
    end
    wait_done_a(lat);
    checks++;
    if (lat !== 19 || sig_a !== SIG_A || pass_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d sig=%h pass=%b exp 19 %h 1", lat, sig_a, pass_a, SIG_A);
    end
    start_a = 0;
    tick();
    checks++;
    if (done_a !== 1'b1 || sig_a !== SIG_A) begin
      errors++;
      $display("FAIL b2b_release got done=%b sig=%h exp 1 %h", done_a, sig_a, SIG_A);
    end
  endtask

  task automatic test_start_toggle();
    int early;
    early = 0;
    start_a = 1; tick();
    for (int i = 1; i <= 19; i++) begin
      start_a = (i % 2 == 1);
      tick();
      if (done_a && i < 19) early++;
    end
    start_a = 0;
    checks++;
    if (early !== 0 || done_a !== 1'b1 || sig_a !== SIG_A || pass_a !== 1'b1 || cnt_a !== 16'd4) begin
      errors++;
      $display("FAIL toggle got early=%0d done=%b sig=%h pass=%b cnt=%0d exp 0 1 %h 1 4", early, done_a, sig_a, pass_a, cnt_a, SIG_A);
    end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_single_window();
    test_mismatch();
    test_settle_ignore();
    test_golden_mismatch();
    test_reset_mid_collect();
    test_back_to_back();
    test_start_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule

// File: doc/design_out_signature_checker.md
DESIGN_OUT_SIGNATURE_CHECKER -- requirements
Module: design_out_signature_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the width of the observed data bus and of the signature.
REQ-002 SHALL have parameter CHANNEL, default 15, giving the settle cycles skipped after start (the DUT pipeline depth); 0 is legal.
REQ-003 SHALL have parameter WINDOW, default 64, giving the cycles compacted per run; legal range 1..65535.
REQ-004 SHALL have parameter POLY, default 32'h04C11DB7, giving the MISR feedback taps, truncated to WIDTH.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: run request, sampled on clk.
REQ-008 SHALL have port out_data, input, WIDTH bits: observed DUT output bus.
REQ-009 SHALL have port golden, input, WIDTH bits: expected signature, sampled on the final COLLECT edge.
REQ-010 SHALL have port busy, output, 1 bit: high in SETTLE or COLLECT.
REQ-011 SHALL have port done, output, 1 bit: high in DONE.
REQ-012 SHALL have port pass, output, 1 bit: result valid while done=1, otherwise 0.
REQ-013 SHALL have port signature, output, WIDTH bits: current MISR contents.
REQ-014 SHALL have port sample_cnt, output, 16 bits: count of samples absorbed in the current run.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, COLLECT and DONE, all outputs registered.
REQ-016 IDLE: start=1 at an edge SHALL clear signature and sample_cnt, and go to SETTLE (CHANNEL>0) or COLLECT (CHANNEL=0).
REQ-017 SETTLE SHALL last exactly CHANNEL cycles, ignoring out_data, then go to COLLECT.
REQ-018 COLLECT SHALL last exactly WINDOW cycles; each edge SHALL set signature <= ((signature<<1) ^ (signature[WIDTH-1] ? POLY : 0) ^ out_data), truncated to WIDTH, and increment sample_cnt.
REQ-019 On the WINDOW-th COLLECT edge SHALL go to DONE and register pass = (next signature == golden).
REQ-020 First absorbed sample SHALL be out_data at edge k+CHANNEL+1, where k is the start edge; done SHALL rise after edge k+CHANNEL+WINDOW.
REQ-021 DONE SHALL hold done, pass, signature and sample_cnt stable until a start edge, which restarts exactly as from IDLE (signature cleared in the same edge).
REQ-022 start SHALL be ignored in SETTLE and COLLECT; a held-high start therefore runs back-to-back with one DONE cycle between runs.
REQ-023 sample_cnt SHALL never exceed WINDOW and SHALL not wrap.

Reset
REQ-024 rst=1 SHALL immediately, without a clock, force IDLE, busy=0, done=0, pass=0, signature=0 and sample_cnt=0, from any state including mid-run.
REQ-025 After rst falls, the block SHALL remain in IDLE until a start edge; a start edge coinciding with rst=1 SHALL be discarded.

Verification
REQ-026 With CHANNEL=15, WINDOW=4, out_data=0, golden=0 and a start pulse, done SHALL rise 19 cycles after start with signature=0, pass=1 and sample_cnt=4.
REQ-027 With CHANNEL=0, WINDOW=1, out_data=32'hABCDEFAB and golden=32'hABCDEFAB, done SHALL rise 1 cycle after start with signature=32'hABCDEFAB and pass=1.
REQ-028 With CHANNEL=0, WINDOW=2, out_data=32'h00000001 constant and golden=32'h00000002, the bench SHALL see signature=32'h00000003, done=1 and pass=0.
REQ-029 Asserting rst for 10 time units mid-COLLECT SHALL drop all outputs to 0 asynchronously; a later start SHALL give the same result as a clean run.
REQ-030 Holding start high SHALL give repeated runs, done pulsing for 1 cycle every CHANNEL+WINDOW+1 cycles, with identical signatures for constant out_data.
REQ-031 Toggling start during SETTLE and COLLECT SHALL leave the timing and signature unchanged versus a single start pulse.
